alu_carry_ctl: RTL and testbench

Carry-control and multi-precision sequencer for the Slipstream ALU. It sits directly upstream of CYMUX: it drives CYMUX's A/B/C data inputs and its SELL_0/SELL_1 selects, and it consumes the ALU's carry-out and zero outputs. It owns the architectural carry and zero flags. It sequences 16-bit single-pass and 32-bit two-pass operations, chaining the low-word carry into the high word.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_carry_ctl.sv | 116 +++++++++++
 tb/tb_alu_carry_ctl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the Slipstream ALU carry/sequencing logic.
package alu_pkg;

  typedef enum logic [1:0] {
    CY_ZERO  = 2'b00,
    CY_ONE   = 2'b01,
    CY_FLAG  = 2'b10,
    CY_NFLAG = 2'b11
  } carry_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LO   = 2'b01,
    HI   = 2'b10,
    DONE = 2'b11
  } state_t;

  // CYMUX select encodings as {sell_1, sell_0}
  localparam logic [1:0] SEL_C = 2'b01;
  localparam logic [1:0] SEL_B = 2'b11;
  localparam logic [1:0] SEL_A = 2'b10;

endpackage

// File: rtl/alu_carry_ctl.sv
// Carry-control and multi-precision sequencer: drives CYMUX, owns the carry/zero
// flags and sequences 16-bit single-pass and 32-bit two-pass ALU operations.
module alu_carry_ctl
  import alu_pkg::*;
(
  input  logic MasterClock,
  input  logic Reset,
  input  logic req_valid,
  output logic req_ready,
  input  logic [1:0] req_mode,
  input  logic req_long,
  input  logic alu_co,
  input  logic alu_zero,
  input  logic cf_load,
  input  logic cf_value,
  output logic cy_a,
  output logic cy_b,
  output logic cy_c,
  output logic sell_0,
  output logic sell_1,
  output logic alu_strobe,
  output logic pass_hi,
  output logic done,
  output logic carry_flag,
  output logic zero_flag
);

  state_t      state_q, state_d;
  carry_mode_t mode_q;
  logic        long_q;
  logic        carry_tmp, zero_tmp;
  logic [1:0]  sel;
  logic        accept;
  logic        final_pass;

  assign accept     = req_valid && (state_q == IDLE);
  // The pass whose carry-out becomes architectural: LO of a short op, HI of a long op.
  assign final_pass = ((state_q == LO) && !long_q) || (state_q == HI);

  assign cy_b = 1'b1;
  assign cy_c = 1'b0;
  assign {sell_1, sell_0} = sel;

  // Everything below decodes registered state only; req_* never reaches CYMUX directly.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    req_ready  = 1'b0;
    alu_strobe = 1'b0;
    pass_hi    = 1'b0;
    done       = 1'b0;
    sel        = SEL_C;
    cy_a       = carry_flag;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = LO;
      end
      LO: begin
        alu_strobe = 1'b1;
        state_d    = long_q ? HI : DONE;
        unique case (mode_q)
          CY_ZERO:  sel = SEL_C;
          CY_ONE:   sel = SEL_B;
          CY_FLAG:  sel = SEL_A;
          CY_NFLAG: begin
            sel  = SEL_A;
            cy_a = ~carry_flag;
          end
        endcase
      end
      HI: begin
        alu_strobe = 1'b1;
        pass_hi    = 1'b1;
        sel        = SEL_A;
        cy_a       = carry_tmp;
        state_d    = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge MasterClock) begin
    if (Reset) begin
      state_q    <= IDLE;
      mode_q     <= CY_ZERO;
      long_q     <= 1'b0;
      carry_tmp  <= 1'b0;
      zero_tmp   <= 1'b0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q <= carry_mode_t'(req_mode);
        long_q <= req_long;
      end
      if (state_q == LO) begin
        carry_tmp <= alu_co;
        zero_tmp  <= alu_zero;
      end
      // An ALU capture on the final pass takes priority over a direct flag write.
      if (final_pass) begin
        carry_flag <= alu_co;
        zero_flag  <= (state_q == HI) ? (zero_tmp & alu_zero) : alu_zero;
      end else if (cf_load) begin
        carry_flag <= cf_value;
      end
    end
  end

endmodule

// File: tb/tb_alu_carry_ctl.sv
// Self-checking bench for alu_carry_ctl with a CYMUX model downstream and a
// cycle-count based reference model of the operation schedule and flags.
module tb_alu_carry_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_mode = 2'b00;
  logic       req_long = 1'b0;
  logic       alu_co = 1'b0;
  logic       alu_zero = 1'b0;
  logic       cf_load = 1'b0;
  logic       cf_value = 1'b0;
  logic       cy_a, cy_b, cy_c, sell_0, sell_1;
  logic       alu_strobe, pass_hi, done, carry_flag, zero_flag;
  logic       z;

  int n_checks = 0;
  int n_pass   = 0;
  bit compare_en = 1'b0;

  always #5 clk = ~clk;

  alu_carry_ctl dut (
    .MasterClock(clk),
    .Reset      (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_long   (req_long),
    .alu_co     (alu_co),
    .alu_zero   (alu_zero),
    .cf_load    (cf_load),
    .cf_value   (cf_value),
    .cy_a       (cy_a),
    .cy_b       (cy_b),
    .cy_c       (cy_c),
    .sell_0     (sell_0),
    .sell_1     (sell_1),
    .alu_strobe (alu_strobe),
    .pass_hi    (pass_hi),
    .done       (done),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag)
  );

  // Downstream CYMUX: 01 -> C, 11 -> B, 10 -> A.
  always_comb begin
    z = 1'b0;
    case ({sell_1, sell_0})
      2'b01:   z = cy_c;
      2'b11:   z = cy_b;
      2'b10:   z = cy_a;
      default: z = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: counts cycles since the accept edge instead of tracking states.
  int       m_age = 0;     // 0 = idle, k = k-th cycle after accept
  bit       m_long = 1'b0;
  bit [1:0] m_mode = 2'b00;
  bit       m_cf = 1'b0, m_zf = 1'b0, m_lo_carry = 1'b0, m_lo_zero = 1'b0;

  function automatic int op_len(input bit lng);
    return lng ? 3 : 2;
  endfunction

  always @(posedge clk) begin
    bit captured;
    captured = 1'b0;
    if (rst) begin
      m_age = 0; m_cf = 0; m_zf = 0; m_lo_carry = 0; m_lo_zero = 0;
    end else begin
      if (m_age == 1) begin
        m_lo_carry = alu_co;
        m_lo_zero  = alu_zero;
        if (!m_long) begin
          m_cf = alu_co; m_zf = alu_zero; captured = 1'b1;
        end
      end else if (m_age == 2 && m_long) begin
        m_cf = alu_co; m_zf = m_lo_zero & alu_zero; captured = 1'b1;
      end
      if (cf_load && !captured) m_cf = cf_value;
      if (m_age == 0) begin
        if (req_valid) begin
          m_age = 1; m_long = req_long; m_mode = req_mode;
        end
      end else if (m_age == op_len(m_long)) m_age = 0;
      else m_age++;
    end
  end

  function automatic bit exp_z();
    if (m_age == 1) begin
      case (m_mode)
        2'd0: return 1'b0;
        2'd1: return 1'b1;
        2'd2: return m_cf;
        default: return ~m_cf;
      endcase
    end
    if (m_age == 2 && m_long) return m_lo_carry;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (compare_en) begin
      check("req_ready",  req_ready,  m_age == 0);
      check("alu_strobe", alu_strobe, m_age == 1 || (m_age == 2 && m_long));
      check("pass_hi",    pass_hi,    m_age == 2 && m_long);
      check("done",       done,       m_age != 0 && m_age == op_len(m_long));
      check("cymux_z",    z,          exp_z());
      check("sel_legal",  {sell_1, sell_0} != 2'b00, 1);
      check("cy_b",       cy_b,       1);
      check("cy_c",       cy_c,       0);
      check("carry_flag", carry_flag, m_cf);
      check("zero_flag",  zero_flag,  m_zf);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic accept_op(input logic [1:0] mode, input logic lng);
    req_valid = 1'b1; req_mode = mode; req_long = lng;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    int dones;
    rst = 1'b1;
    step(); step();
    check("rst_ready", req_ready, 1);
    check("rst_sel", {sell_1, sell_0, cy_a, cy_b, cy_c}, 5'b01010);
    check("rst_misc", {alu_strobe, pass_hi, done, carry_flag, zero_flag}, 5'b0);
    rst = 1'b0;
    compare_en = 1'b1;

    // Reset mid-HI with carry_flag set.
    cf_load = 1'b1; cf_value = 1'b1; step(); cf_load = 1'b0;
    check("pre_cf", carry_flag, 1);
    accept_op(2'd0, 1'b1);
    step();
    check("in_hi", pass_hi, 1);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_hi_cf", carry_flag, 0);
    check("rst_hi_ready", req_ready, 1);
    dones = 0;
    repeat (4) begin step(); dones += done; end
    check("rst_hi_nodone", dones, 0);

    // Short, mode 01.
    accept_op(2'd1, 1'b0);
    alu_co = 1'b1; alu_zero = 1'b0;
    check("s01_lo_z", z, 1);
    step();
    check("s01_done", done, 1);
    check("s01_flags", {carry_flag, zero_flag}, 2'b10);
    step();

    // Long, mode 00.
    accept_op(2'd0, 1'b1);
    check("l00_lo_z", z, 0);
    alu_co = 1'b1; alu_zero = 1'b1;
    step();
    check("l00_hi_z", z, 1);
    check("l00_pass_hi", pass_hi, 1);
    alu_co = 1'b0; alu_zero = 1'b1;
    step();
    check("l00_done", done, 1);
    check("l00_flags", {carry_flag, zero_flag}, 2'b01);
    step();

    // Long, mode 10 with carry_flag = 1.
    cf_load = 1'b1; cf_value = 1'b1; step(); cf_load = 1'b0;
    accept_op(2'd2, 1'b1);
    check("l10_lo_z", z, 1);
    alu_zero = 1'b0;
    step();
    alu_zero = 1'b1;
    step();
    check("l10_zf", zero_flag, 0);
    step();

    // Mode 11, carry_flag 0, then cf_load(1) in the accept cycle.
    cf_load = 1'b1; cf_value = 1'b0; step(); cf_load = 1'b0;
    accept_op(2'd3, 1'b0);
    check("s11_lo_z", z, 1);
    step(); step();
    cf_load = 1'b1; cf_value = 1'b1;
    accept_op(2'd3, 1'b0);
    cf_load = 1'b0;
    check("s11_cfload_z", z, 0);
    step(); step();

    // cf_load(0) coincident with the final pass: capture wins.
    accept_op(2'd0, 1'b0);
    alu_co = 1'b1; cf_load = 1'b1; cf_value = 1'b0;
    step();
    cf_load = 1'b0;
    check("cf_collide", carry_flag, 1);
    step();

    // req_valid held while busy: exactly one operation.
    req_valid = 1'b1; req_mode = 2'd1; req_long = 1'b0;
    dones = 0;
    step(); step();
    dones += done;
    req_valid = 1'b0;
    repeat (4) begin step(); dones += done; end
    check("held_one_op", dones, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      req_mode  = 2'($urandom_range(0, 3));
      req_long  = ($urandom_range(0, 1) == 1);
      alu_co    = ($urandom_range(0, 1) == 1);
      alu_zero  = ($urandom_range(0, 1) == 1);
      cf_load   = ($urandom_range(0, 3) == 0);
      cf_value  = ($urandom_range(0, 1) == 1);
      rst       = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0; req_valid = 1'b0; cf_load = 1'b0;
    step(); step();
    compare_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
